// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink sequencer.
// Holds the FSM state encoding and the width of the per-sequence blink count.
package blink_pkg;
  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;
endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter used to time the LED on/off phases.
// Ports:
//   i_Clk      - system clock
//   i_Rst_L    - synchronous active-low reset (count returns to 0)
//   i_Load     - load i_Load_Val this cycle (wins over counting)
//   i_Load_Val - value to load; the phase then lasts i_Load_Val+1 cycles
//   o_Done     - high while the count is zero
module cycle_timer #(
  parameter int W = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         i_Load,
  input  logic [W-1:0] i_Load_Val,
  output logic         o_Done
);
  logic [W-1:0] cnt;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L)          cnt <= '0;
    else if (i_Load)       cnt <= i_Load_Val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign o_Done = (cnt == '0);
endmodule

// File: rtl/led_blink_sequencer.sv
// Turns single-cycle event pulses into timed LED blink sequences.
// Each accepted event plays i_Count on/off blinks; events that arrive while a
// sequence is playing are counted (saturating at PENDING_MAX) and replayed.
// Ports:
//   i_Clk   - system clock
//   i_Rst_L - synchronous active-low reset; aborts any sequence
//   i_Event - single-cycle request pulse
//   i_Count - blinks per sequence, sampled when a sequence starts
//   o_LED   - LED drive (registered), high exactly in ON
//   o_Busy  - high whenever not IDLE (registered)
//   o_Drop  - one-cycle pulse when an event is lost to saturation
module led_blink_sequencer
  import blink_pkg::*;
#(
  parameter int CLKS_ON     = 6250000,
  parameter int CLKS_OFF    = 6250000,
  parameter int PENDING_MAX = 3
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Event,
  input  logic [COUNT_W-1:0] i_Count,
  output logic               o_LED,
  output logic               o_Busy,
  output logic               o_Drop
);
  localparam int TMAX = (CLKS_ON > CLKS_OFF) ? CLKS_ON : CLKS_OFF;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int PW   = $clog2(PENDING_MAX + 1);

  localparam logic [TW-1:0] ON_LD  = TW'(CLKS_ON - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(CLKS_OFF - 1);
  localparam logic [PW-1:0] PMAX   = PW'(PENDING_MAX);

  state_t             state, nxt;
  logic [COUNT_W-1:0] blinks;
  logic [PW-1:0]      pending;

  logic ev_ok, start, direct, take, inc;
  logic on_end, off_next, t_done, t_load;
  logic [TW-1:0] t_val;

  // Zero-count events are ignored outright.
  assign ev_ok    = i_Event && (i_Count != '0);
  assign take     = (state == IDLE) && (pending != '0);
  assign direct   = (state == IDLE) && (pending == '0) && ev_ok;
  assign start    = take || direct;
  // A direct start consumes the event itself; anything else queues it.
  assign inc      = ev_ok && !direct;
  assign on_end   = (state == ON) && t_done;
  assign off_next = (state == OFF) && t_done && (blinks > COUNT_W'(1));

  assign t_load = start || on_end || off_next;
  assign t_val  = on_end ? OFF_LD : ON_LD;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start)  nxt = ON;
      ON:      if (t_done) nxt = OFF;
      OFF:     if (t_done) nxt = off_next ? ON : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state   <= IDLE;
      blinks  <= '0;
      pending <= '0;
      o_LED   <= 1'b0;
      o_Busy  <= 1'b0;
      o_Drop  <= 1'b0;
    end else begin
      state  <= nxt;
      o_LED  <= (nxt == ON);
      o_Busy <= (nxt != IDLE);
      o_Drop <= 1'b0;

      // Same-cycle increment and replay-take cancel out.
      if (inc && !take) begin
        if (pending == PMAX) o_Drop  <= 1'b1;
        else                 pending <= pending + 1'b1;
      end else if (take && !inc) begin
        pending <= pending - 1'b1;
      end

      if (start)         blinks <= i_Count;
      else if (off_next) blinks <= blinks - 1'b1;
    end
  end

  cycle_timer #(.W(TW)) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Load     (t_load),
    .i_Load_Val (t_val),
    .o_Done     (t_done)
  );
endmodule

// File: doc/led_blink_sequencer.md
# led_blink_sequencer

Converts single-cycle event pulses (from the debounced-switch edge detectors) into a timed LED blink sequence. Each accepted event produces a programmable number of on/off LED blinks. Events arriving while a sequence is playing are counted and replayed in order. Sits between the switch/edge-detect front end and the board LED pins, and is the output-side counterpart to the debounce path.

## Interface
- `CLKS_ON`, default 6250000: cycles the LED is high per blink (250 ms at 25 MHz); must be ≥1.
- `CLKS_OFF`, default 6250000: cycles the LED is low after each blink; must be ≥1.
- `PENDING_MAX`, default 3: saturation value of the pending-event counter; must be ≥1.
- `i_Clk`  in  1: system clock. One clock domain only.
- `i_Rst_L`  in  1: reset, synchronous and active-low.
- `i_Event`  in  1: single-cycle request pulse.
- `i_Count`  in  4: blinks per sequence; sampled only when a sequence starts.
- `o_LED`  out  1: LED drive, registered.
- `o_Busy`  out  1: high whenever state ≠ IDLE.
- `o_Drop`  out  1: one-cycle pulse when an event is lost to counter saturation.

## Operation
- States: IDLE, ON, OFF.
  - IDLE→ON when (`i_Event` and `i_Count`≠0) or pending>0. On entry, latch `i_Count` into the blink counter and load the timer with `CLKS_ON`−1.
  - ON→OFF when the timer reaches 0; load `CLKS_OFF`−1.
  - OFF→ON when the timer reaches 0 and blinks remaining >1. Decrement the blink count and load `CLKS_ON`−1.
  - OFF→IDLE when the timer reaches 0 on the last blink.
- `o_LED` = 1 exactly while in ON.
- An event with `i_Count`=0 is ignored: it is neither counted nor started, and `o_Drop` stays 0.
- Pending counter:
  - An event that starts a sequence directly from IDLE with pending=0 does not touch the counter.
  - Any other valid event increments the counter.
  - Each start taken from the counter decrements it.
  - A same-cycle increment and decrement leave it unchanged.
  - A valid event arriving when pending=`PENDING_MAX` (and no same-cycle decrement) is dropped and pulses `o_Drop`.
- Replayed sequences use the `i_Count` value present at their start cycle, not the value present at event time.
- Timer width: $clog2(max(`CLKS_ON`,`CLKS_OFF`)), minimum 1. Pending counter width: $clog2(`PENDING_MAX`+1). No wrap-around is allowed; the pending counter saturates.

## Timing
- Reset (`i_Rst_L`=0 at a rising edge): state IDLE; `o_LED`=0, `o_Busy`=0, `o_Drop`=0; pending=0; timer=0. Reset mid-sequence aborts immediately, so `o_LED` is 0 in the cycle after the reset edge.
- Latency: `i_Event` in IDLE at edge T gives `o_LED`=`o_Busy`=1 from T+1.
- A sequence of N blinks spans N·(`CLKS_ON`+`CLKS_OFF`) cycles of `o_Busy`=1.
- Back-to-back sequences from pending are separated by exactly one IDLE cycle (`o_Busy`=0 for one cycle).
- `o_Drop` is asserted in the cycle after the dropped event, for one cycle.
- `i_Event` is treated as a pulse: each high cycle counts as one event.

## Structure
- Shared package `blink_pkg`: state encoding constants (IDLE=2'd0, ON=2'd1, OFF=2'd2) and the blink-count width (4).
- One sub-module, `cycle_timer`:
  - Parameterised down-counter with load value and `o_Done` at zero.
  - Instantiated once; the FSM selects the load value.
- The FSM, blink counter and pending counter live in `led_blink_sequencer`.

## Test plan
Parameters for all scenarios: `CLKS_ON`=4, `CLKS_OFF`=3, `PENDING_MAX`=2.
- Reset: hold `i_Rst_L`=0 for 5 cycles with `i_Event` toggling → `o_LED`, `o_Busy`, `o_Drop` all 0; no sequence starts after release.
- Single event: `i_Event` at cycle 10 with `i_Count`=2 → `o_LED`=1 in cycles 11–14 and 18–21, 0 in 15–17 and 22–24; `o_Busy`=1 in cycles 11–24, 0 in cycle 25.
- Queued events: `i_Count`=1; events at cycles 10, 12, 13 → busy windows 11–17, 19–25, 27–33; `o_Drop` never asserts.
- Overflow: `i_Count`=1; events at cycles 10, 12, 13, 14 → the cycle-14 event drops; `o_Drop`=1 only in cycle 15; exactly three sequences play.
- Zero count: `i_Event` with `i_Count`=0 in IDLE → `o_Busy` stays 0 and pending stays 0; a subsequent event with `i_Count`=1 plays exactly one blink.
- Reset mid-sequence: `i_Count`=3, plus one queued event; assert reset during the second ON → `o_LED`=0 in the next cycle, pending=0, and no replay after release.
